dm_port_arbiter: RTL

Two-port arbiter and access sequencer in front of the shared data memory. It lets the pipeline M stage (port 0) and a secondary requester such as a debug or loader bridge (port 1) share one single-ported, synchronous-read data RAM. It grants one transaction at a time using round-robin, checks the address range, and performs byte and halfword stores as a read-modify-write. Each transaction returns a one-cycle ack to its requester.

---
 rtl/dm_arb_pkg.sv | 31 +++
 rtl/dm_port_arbiter_if.sv | 41 ++++
 rtl/rr_arb2.sv | 26 ++
 rtl/dm_port_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
//   DEPTH_DEF / ADDR_W_DEF : default RAM size (words) and word-address width
//   state_t                : sequencer state encoding
//   be_legal()             : true for the byte-enable patterns a requester may issue
//   be_mask()              : expands a 4-bit byte enable into a 32-bit lane mask
package dm_arb_pkg;

  localparam int DEPTH_DEF  = 3072;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      4'b1111, 4'b0011, 4'b1100,
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Bundle of the two requester ports and the RAM port of dm_port_arbiter.
//   p0_* / p1_* : req/we/be/addr/wdata (p0 also pc) in, ack/rdata/err out
//   mem_*       : en/we/addr/wdata out, rdata in (one cycle after a read strobe)
// Handshake: a requester raises req with stable fields and holds them until
// it sees a one-cycle ack; rdata/err are valid only with ack. It must drop req
// or present a new transaction in the cycle after ack.
// modport slave is the arbiter side, modport master the requester/RAM side.
interface dm_port_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic              p0_req, p1_req;
  logic              p0_we, p1_we;
  logic [3:0]        p0_be, p1_be;
  logic [31:0]       p0_addr, p1_addr;
  logic [31:0]       p0_wdata, p1_wdata;
  logic [31:0]       p0_pc;
  logic              p0_ack, p1_ack;
  logic [31:0]       p0_rdata, p1_rdata;
  logic              p0_err, p1_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_be, p1_be,
           p0_addr, p1_addr, p0_wdata, p1_wdata, p0_pc, mem_rdata,
    output p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_be, p1_be,
           p0_addr, p1_addr, p0_wdata, p1_wdata, p0_pc, mem_rdata,
    input  p0_ack, p1_ack, p0_rdata, p1_rdata, p0_err, p1_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request lines
//   advance    : commit the current grant (arbiter sampling in IDLE)
//   gnt[1:0]   : one-hot grant, combinational from req and last_gnt
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  // Index of the port granted most recently; resets to 1 so port 0 wins
  // the first tie.
  logic last_gnt;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        last_gnt <= 1'b1;
    else if (advance) last_gnt <= gnt[1];
  end
endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter / access sequencer for the single-ported data RAM.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : dm_port_arbiter_if.slave (requester ports and RAM port)
//   busy       : high whenever the sequencer is not IDLE
//   dbg_state  : current sequencer state
// Sub-byte stores are done as read-modify-write (RD, WAIT, WR).
// Optional build macro DM_ARB_LOG_EN prints one line per RAM write.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  dm_port_arbiter_if.slave   bus,
  output logic               busy,
  output state_t             dbg_state
);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t      state, state_nx;
  logic [1:0]  gnt;
  logic        advance;

  // Fields of the transaction in flight.
  logic        port_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] merged_q;

  // Winner's fields, selected by the grant.
  logic        w_sel, w_we, w_err;
  logic [3:0]  w_be, w_be_n;
  logic [31:0] w_addr, w_wdata;
  logic [31:0] mask_q;

  assign advance = (state == ST_IDLE) && (bus.p0_req || bus.p1_req);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.p1_req, bus.p0_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  assign w_sel   = gnt[1];
  assign w_we    = w_sel ? bus.p1_we    : bus.p0_we;
  assign w_be    = w_sel ? bus.p1_be    : bus.p0_be;
  assign w_addr  = w_sel ? bus.p1_addr  : bus.p0_addr;
  assign w_wdata = w_sel ? bus.p1_wdata : bus.p0_wdata;
  // Unknown byte-enable patterns degrade to a full-word store.
  assign w_be_n  = be_legal(w_be) ? w_be : 4'hF;
  assign w_err   = {2'b00, w_addr[31:2]} >= DEPTH_W;
  assign mask_q  = be_mask(be_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (advance) begin
          if (w_err)                         state_nx = ST_RESP;
          else if (!w_we || w_be_n != 4'hF)  state_nx = ST_RD;
          else                               state_nx = ST_WR;
        end
      end
      ST_RD:   state_nx = ST_WAIT;
      ST_WAIT: state_nx = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      pc_q     <= 32'h0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      merged_q <= 32'h0;
    end else if (advance) begin
      port_q   <= w_sel;
      we_q     <= w_we;
      be_q     <= w_be_n;
      addr_q   <= w_addr;
      wdata_q  <= w_wdata;
      pc_q     <= bus.p0_pc;
      err_q    <= w_err;
      // Cleared here so writes and range errors respond with zero.
      rdata_q  <= 32'h0;
      // Full writes go straight to WR with this; partial writes overwrite it.
      merged_q <= w_wdata;
    end else if (state == ST_WAIT) begin
      if (we_q) merged_q <= (bus.mem_rdata & ~mask_q) | (wdata_q & mask_q);
      else      rdata_q  <= bus.mem_rdata;
    end
  end

  always_comb begin
    bus.mem_en    = (state == ST_RD) || (state == ST_WR);
    bus.mem_we    = (state == ST_WR);
    bus.mem_addr  = addr_q[ADDR_W+1:2];
    bus.mem_wdata = merged_q;
    bus.p0_ack    = (state == ST_RESP) && !port_q;
    bus.p1_ack    = (state == ST_RESP) &&  port_q;
    bus.p0_rdata  = bus.p0_ack ? rdata_q : 32'h0;
    bus.p1_rdata  = bus.p1_ack ? rdata_q : 32'h0;
    bus.p0_err    = bus.p0_ack & err_q;
    bus.p1_err    = bus.p1_ack & err_q;
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // Address bits outside the RAM window and the PC only feed the write log.
  logic unused_ok;
  assign unused_ok = ^{addr_q[31:ADDR_W+2], addr_q[1:0], pc_q};

`ifdef DM_ARB_LOG_EN
  always @(posedge clk) begin
    if (!reset && state == ST_WR)
      $display("%d@%h: *%h <= %h", $time, port_q ? 32'h0 : pc_q,
               {addr_q[31:2], 2'b00}, merged_q);
  end
`else
`endif

endmodule
